// File: rtl/decryption_pipe.sv
// Five-stage registered decrypter: inverts the encrypt chain one operation per stage,
// with valid/ready flow control, whole-pipe stall on back-pressure and a delivered-word counter.
module decryption_pipe #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy,
  output logic [CW-1:0] word_count,
  input  logic          clear_count
);
  localparam int STAGES = 5;

  logic [STAGES:1]          vld_pipe;
  logic [STAGES:1][N-1:0]   dat_pipe;
  // Key rides alongside its word up to the XOR stage; stage 5 consumes it.
  logic [STAGES-1:1][N-1:0] key_pipe;
  logic                     adv;

  function automatic logic [N-1:0] rotr5(input logic [N-1:0] d);
    return {d[4:0], d[N-1:5]};
  endfunction

  function automatic logic [N-1:0] rotl5(input logic [N-1:0] d);
    return {d[N-6:0], d[N-1:N-5]};
  endfunction

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = d[N-1-i];
    return r;
  endfunction

  // Whole pipe moves or whole pipe holds; bubbles are not squeezed out.
  assign adv      = ~vld_pipe[STAGES] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      key_pipe <= '0;
    end else if (adv) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], in_valid};
      dat_pipe[1] <= rotr5(in_data);
      dat_pipe[2] <= bitrev(dat_pipe[1]);
      dat_pipe[3] <= ~dat_pipe[2];
      dat_pipe[4] <= rotl5(dat_pipe[3]);
      dat_pipe[5] <= dat_pipe[4] ^ key_pipe[4];
      key_pipe    <= {key_pipe[STAGES-2:1], in_key};
    end
  end

  // Saturating delivery counter; clear takes priority over a coincident delivery.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      word_count <= '0;
    else if (clear_count)
      word_count <= '0;
    else if (out_valid && out_ready && (word_count != {CW{1'b1}}))
      word_count <= word_count + CW'(1);
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_decryption_pipe.sv
// Bench for decryption_pipe: table vectors, latency/stall/reset sequences, random
// encrypt->decrypt round trips against a scoreboard, and a CW=4 saturation instance.
module tb_decryption_pipe;
  logic       clock = 0;
  logic       reset_n = 0;
  logic       in_valid = 0, out_ready = 1, clear_count = 0;
  logic [7:0] in_data = 0, in_key = 0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic [15:0] word_count;

  logic       c4_in_valid = 0, c4_clear = 0;
  logic [7:0] c4_in_data = 0, c4_in_key = 0;
  logic       c4_in_ready, c4_out_valid, c4_busy;
  logic [7:0] c4_out_data;
  logic [3:0] c4_word_count;

  always #5 clock = ~clock;

  decryption_pipe #(.N(8), .CW(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .word_count(word_count), .clear_count(clear_count));

  decryption_pipe #(.N(8), .CW(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
    .in_data(c4_in_data), .in_key(c4_in_key), .out_valid(c4_out_valid), .out_ready(1'b1),
    .out_data(c4_out_data), .busy(c4_busy), .word_count(c4_word_count), .clear_count(c4_clear));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encrypter model: XOR key, rotate right 5, invert, reverse bits, rotate left 5.
  function automatic logic [7:0] encrypt(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] a, r;
    a = d ^ k;
    a = (a >> 5) | (a << 3);
    a = ~a;
    for (int i = 0; i < 8; i++) r[7-i] = a[i];
    return (r << 5) | (r >> 3);
  endfunction

  typedef struct { logic [7:0] d; logic [7:0] k; logic [7:0] exp; } vec_t;
  vec_t tbl[6];

  // Scoreboard monitor: plaintext queue in acceptance order, count and stall models.
  logic [7:0] exp_plain = 0;
  logic [7:0] q[$];
  logic       mon_en = 0, prev_stall = 0, rand_rdy = 0;
  logic [7:0] prev_data = 0;
  logic [15:0] exp_cnt = 0;
  int cyc = 0, del_first = -1, del_last = -1;

  always @(negedge clock) begin
    cyc++;
    if (!mon_en) prev_stall = 0;
    else begin
      check("word_count", word_count, exp_cnt);
      check("busy", busy, q.size() != 0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: got %0h with no word outstanding at %0t", out_data, $time);
        end else check("out_data", out_data, q.pop_front());
        if (del_first < 0) del_first = cyc;
        del_last = cyc;
      end
      if (clear_count) exp_cnt = 0;
      else if (out_valid && out_ready && exp_cnt != 16'hFFFF) exp_cnt++;
      if (in_valid && in_ready) q.push_back(exp_plain);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic cycle();
    @(posedge clock); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] k, input logic [7:0] plain);
    in_valid = 1; in_data = d; in_key = k; exp_plain = plain;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (in_ready) begin
        cycle();
        in_valid = 0;
        return;
      end
      cycle();
    end
    check("send_timeout", 1, 0);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (q.size() == 0) begin cycle(); cycle(); return; end
      cycle();
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_snap;
    logic [7:0]  d, k;
    tbl[0] = '{8'h99, 8'h3C, 8'hA5};
    tbl[1] = '{8'hFF, 8'h00, 8'h00};
    tbl[2] = '{8'h99, 8'h00, 8'h99};
    tbl[3] = '{8'h00, 8'h00, 8'hFF};
    tbl[4] = '{8'h00, 8'hFF, 8'h00};
    tbl[5] = '{8'h01, 8'hFD, 8'h00};

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1; mon_en = 1;

    // Single word latency: accepted at E1, visible after E5
    in_valid = 1; in_data = 8'h99; in_key = 8'h3C; exp_plain = 8'hA5;
    @(posedge clock); #1; in_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock); check("lat_early_valid", out_valid, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'hA5);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat_count", word_count, 1);
    check("lat_busy_fall", busy, 0);
    @(posedge clock); #1;

    // Table vectors back-to-back: each word with its own key, consecutive outputs
    del_first = -1;
    for (int i = 0; i < 6; i++) send(tbl[i].d, tbl[i].k, tbl[i].exp);
    drain();
    check("tbl_consecutive", del_last - del_first, 5);

    // Fill pipe with out_ready low, hold 10 cycles, then release
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(tbl[i].d, tbl[i].k, tbl[i].exp);
    cnt_snap = exp_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_in_ready", in_ready, 0);
      check("stall_first", out_data, tbl[0].exp);
      check("stall_count", word_count, cnt_snap);
      @(posedge clock); #1;
    end
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); check("burst_valid", out_valid, 1);
      @(posedge clock); #1;
    end
    drain();

    // Random round trips with gaps and random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom); k = 8'($urandom);
      send(encrypt(d, k), k, d);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) cycle();
    end
    rand_rdy = 0; out_ready = 1;
    drain();

    // Asynchronous reset with 3 words in flight
    for (int i = 0; i < 3; i++) send(tbl[i].d, tbl[i].k, tbl[i].exp);
    mon_en = 0;
    #2 reset_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_count", word_count, 0);
    check("arst_in_ready", in_ready, 1);
    q.delete(); exp_cnt = 0;
    @(posedge clock); #1;
    reset_n = 1; mon_en = 1;
    repeat (8) cycle();
    send(8'h99, 8'h3C, 8'hA5);
    drain();

    // CW=4: saturation at 15, then clear wins over a coincident delivery
    c4_in_valid = 1;
    for (int i = 0; i < 17; i++) begin
      c4_in_data = 8'($urandom); c4_in_key = 8'($urandom);
      @(posedge clock); #1;
    end
    c4_in_valid = 0;
    repeat (8) cycle();
    check("c4_saturate", c4_word_count, 15);
    c4_in_valid = 1;
    @(posedge clock); #1;
    c4_in_valid = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (c4_out_valid) break;
    end
    check("c4_valid_before_clear", c4_out_valid, 1);
    c4_clear = 1;
    @(posedge clock); #1;
    c4_clear = 0;
    check("c4_clear", c4_word_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
